// File: rtl/maze_tile_map.sv
// Writable maze tile map: reloads INIT_MAP after reset, clears eaten pellets with a live
// pellet count, and renders walls/pellets to the VGA pixel stream with one-cycle latency.
module maze_tile_map #(
  parameter int unsigned MAP_W     = 28,
  parameter int unsigned MAP_H     = 30,
  parameter int unsigned TILE_LOG2 = 4,
  parameter int unsigned X_OFS     = 96,
  parameter logic [2*MAP_W-1:0] INIT_MAP [0:MAP_H-1] = '{
    56'h55555555555555, 56'h6AAAAA96AAAAA9, 56'h65595596556559, 56'h7559559655655D,
    56'h65595596556559, 56'h6AAAAAAAAAAAA9, 56'h65596555596559, 56'h65596555596559,
    56'h6AA96A96A96AA9, 56'h55515514554555, 56'h55515514554555, 56'h55514000014555,
    56'h55514555514555, 56'h40000400100001, 56'h55514555514555, 56'h55514000014555,
    56'h55514555514555, 56'h55514555514555, 56'h40000014000001, 56'h45515514554551,
    56'h65595596556559, 56'h6A5AAAAAAAA5A9, 56'h56596555596595, 56'h7AA96A96A96AAD,
    56'h65555596555559, 56'h65555596555559, 56'h6AAAAAAAAAAAA9, 56'h65596555596559,
    56'h6AA96AAAA96AA9, 56'h55555555555555
  },
  parameter int unsigned CNT_W     = 10
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [9:0]       drawX,
  input  logic [9:0]       drawY,
  input  logic             eat_req,
  input  logic [4:0]       eat_x,
  input  logic [4:0]       eat_y,
  output logic             ready,
  output logic             eat_pellet,
  output logic             eat_power,
  output logic [CNT_W-1:0] pellets_left,
  output logic             all_eaten,
  output logic [4:0]       R,
  output logic [4:0]       G,
  output logic [4:0]       B
);

  localparam int unsigned XW = (MAP_W > 1) ? $clog2(MAP_W) : 1;
  localparam int unsigned YW = (MAP_H > 1) ? $clog2(MAP_H) : 1;
  localparam int unsigned T  = 1 << TILE_LOG2;

  localparam logic [9:0]  XO   = 10'(X_OFS);
  localparam logic [10:0] PF_W = 11'(MAP_W << TILE_LOG2);
  localparam logic [10:0] PF_H = 11'(MAP_H << TILE_LOG2);
  localparam logic [5:0]  EW   = 6'(MAP_W);
  localparam logic [5:0]  EH   = 6'(MAP_H);

  localparam logic [XW-1:0] X_LAST = XW'(MAP_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(MAP_H - 1);

  localparam logic [TILE_LOG2-1:0] P_LO = TILE_LOG2'(T/2 - 2);
  localparam logic [TILE_LOG2-1:0] P_HI = TILE_LOG2'(T/2 + 1);
  localparam logic [TILE_LOG2-1:0] W_LO = TILE_LOG2'(T/4);
  localparam logic [TILE_LOG2-1:0] W_HI = TILE_LOG2'(3*T/4 - 1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t state, state_nx;

  logic [2*MAP_W-1:0] grid [MAP_H];

  logic [XW-1:0] init_x;
  logic [YW-1:0] init_y;
  logic [1:0]    init_code;
  logic          last_cell;

  logic [XW-1:0] eat_xi;
  logic [YW-1:0] eat_yi;
  logic [1:0]    eat_code;
  logic          eat_in, eat_hit;

  logic [9:0]           px;
  logic [XW-1:0]        mapx;
  logic [YW-1:0]        mapy;
  logic [TILE_LOG2-1:0] lx, ly;
  logic [1:0]           pix_code;
  logic                 in_pf, pel_win, pow_win;
  logic [4:0]           r_nx, g_nx, b_nx;

  assign init_code = INIT_MAP[init_y][{init_x, 1'b0} +: 2];
  assign last_cell = (init_x == X_LAST) && (init_y == Y_LAST);

  assign eat_xi   = eat_x[XW-1:0];
  assign eat_yi   = eat_y[YW-1:0];
  assign eat_in   = ({1'b0, eat_x} < EW) && ({1'b0, eat_y} < EH);
  assign eat_code = grid[eat_yi][{eat_xi, 1'b0} +: 2];

  // px wraps for drawX < X_OFS; in_pf masks that case before the tile code is used
  assign px       = drawX - XO;
  assign mapx     = px[TILE_LOG2 +: XW];
  assign mapy     = drawY[TILE_LOG2 +: YW];
  assign lx       = px[TILE_LOG2-1:0];
  assign ly       = drawY[TILE_LOG2-1:0];
  assign in_pf    = (drawX >= XO) && ({1'b0, px} < PF_W) && ({1'b0, drawY} < PF_H);
  assign pix_code = grid[mapy][{mapx, 1'b0} +: 2];
  assign pel_win  = (lx >= P_LO) && (lx <= P_HI) && (ly >= P_LO) && (ly <= P_HI);
  assign pow_win  = (lx >= W_LO) && (lx <= W_HI) && (ly >= W_LO) && (ly <= W_HI);

  assign all_eaten = ready && (pellets_left == '0);

  always_comb begin
    state_nx = state;
    eat_hit  = 1'b0;
    case (state)
      S_INIT:  if (last_cell) state_nx = S_RUN;
      S_RUN:   eat_hit = eat_req && eat_in && eat_code[1];
      default: state_nx = S_INIT;
    endcase
  end

  always_comb begin
    r_nx = '0;
    g_nx = '0;
    b_nx = '0;
    if (ready && in_pf) begin
      case (pix_code)
        2'b01: b_nx = 5'h0A;
        2'b10: if (pel_win) {r_nx, g_nx, b_nx} = {5'h1F, 5'h1C, 5'h14};
        2'b11: if (pow_win) {r_nx, g_nx, b_nx} = {5'h1F, 5'h1C, 5'h14};
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= S_INIT;
      init_x       <= '0;
      init_y       <= '0;
      pellets_left <= '0;
      ready        <= 1'b0;
      eat_pellet   <= 1'b0;
      eat_power    <= 1'b0;
    end else begin
      state      <= state_nx;
      eat_pellet <= eat_hit && !eat_code[0];
      eat_power  <= eat_hit && eat_code[0];
      if (state == S_INIT) begin
        if (init_x == X_LAST) begin
          init_x <= '0;
          init_y <= init_y + 1'b1;
        end else begin
          init_x <= init_x + 1'b1;
        end
        if (init_code[1]) pellets_left <= pellets_left + 1'b1;
        if (last_cell) ready <= 1'b1;
      end else if (eat_hit && (pellets_left != '0)) begin
        pellets_left <= pellets_left - 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      R <= '0;
      G <= '0;
      B <= '0;
    end else begin
      R <= r_nx;
      G <= g_nx;
      B <= b_nx;
    end
  end

  // Grid is not reset: INIT rewrites every cell before ready is raised
  always_ff @(posedge Clk) begin
    if (state == S_INIT) begin
      grid[init_y][{init_x, 1'b0} +: 2] <= init_code;
    end else if (eat_hit) begin
      grid[eat_yi][{eat_xi, 1'b0} +: 2] <= 2'b00;
    end
  end

endmodule

// File: tb/tb_maze_tile_map.sv
// Bench for maze_tile_map on a 4x3 map: directed scenarios plus randomized pixel/eat traffic
// checked against a tile-array model.
module tb_maze_tile_map;

  localparam int MW = 4;
  localparam int MH = 3;
  localparam int TS = 16;
  localparam logic [7:0] INIT [0:2] = '{8'h55, 8'h79, 8'h55};
  localparam logic [14:0] PEL_RGB  = {5'h1F, 5'h1C, 5'h14};
  localparam logic [14:0] WALL_RGB = {5'h00, 5'h00, 5'h0A};

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [9:0] drawX = '0, drawY = '0;
  logic       eat_req = 1'b0;
  logic [4:0] eat_x = '0, eat_y = '0;
  logic       ready, eat_pellet, eat_power, all_eaten;
  logic [9:0] pellets_left;
  logic [4:0] R, G, B;

  maze_tile_map #(
    .MAP_W(MW), .MAP_H(MH), .TILE_LOG2(4), .X_OFS(0), .INIT_MAP(INIT), .CNT_W(10)
  ) dut (
    .Clk(Clk), .Reset(Reset), .drawX(drawX), .drawY(drawY),
    .eat_req(eat_req), .eat_x(eat_x), .eat_y(eat_y),
    .ready(ready), .eat_pellet(eat_pellet), .eat_power(eat_power),
    .pellets_left(pellets_left), .all_eaten(all_eaten), .R(R), .G(G), .B(B)
  );

  always #5 Clk = ~Clk;

  // tile codes: 0 empty, 1 wall, 2 pellet, 3 power
  int init_map [0:2][0:3] = '{'{1, 1, 1, 1}, '{1, 2, 3, 1}, '{1, 1, 1, 1}};
  int m_map    [0:2][0:3];
  bit m_ready;
  int m_k, m_cnt;
  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pellets_in_first(input int k);
    int n = 0;
    for (int i = 0; i < k; i++) if (init_map[i / MW][i % MW] >= 2) n++;
    return n;
  endfunction

  function automatic logic [14:0] ref_rgb(input int dx, input int dy);
    int tx, ty, lx, ly, c;
    if (!m_ready || dx >= MW * TS || dy >= MH * TS) return '0;
    tx = dx / TS; ty = dy / TS; lx = dx % TS; ly = dy % TS;
    c = m_map[ty][tx];
    if (c == 1) return WALL_RGB;
    if (c == 2 && lx >= 6 && lx <= 9 && ly >= 6 && ly <= 9) return PEL_RGB;
    if (c == 3 && lx >= 4 && lx <= 11 && ly >= 4 && ly <= 11) return PEL_RGB;
    return '0;
  endfunction

  task automatic cycle(input int dx, input int dy, input bit er, input int ex, input int ey);
    logic [14:0] e_rgb;
    bit e_pel, e_pow;
    int c;
    drawX = 10'(dx); drawY = 10'(dy);
    eat_req = er; eat_x = 5'(ex); eat_y = 5'(ey);
    e_rgb = ref_rgb(dx, dy);
    e_pel = 0; e_pow = 0;
    if (m_ready) begin
      if (er && ex < MW && ey < MH) begin
        c = m_map[ey][ex];
        if (c >= 2) begin
          m_map[ey][ex] = 0;
          if (m_cnt > 0) m_cnt--;
          e_pel = (c == 2);
          e_pow = (c == 3);
        end
      end
    end else begin
      m_k++;
      if (m_k == MW * MH) begin
        m_ready = 1;
        m_map = init_map;
        m_cnt = pellets_in_first(MW * MH);
      end
    end
    @(posedge Clk); #1;
    eat_req = 1'b0;
    check("rgb", {17'b0, R, G, B}, {17'b0, e_rgb});
    check("eat_pellet", {31'b0, eat_pellet}, {31'b0, e_pel});
    check("eat_power", {31'b0, eat_power}, {31'b0, e_pow});
    check("ready", {31'b0, ready}, {31'b0, m_ready});
    check("pellets_left", {22'b0, pellets_left}, m_ready ? m_cnt : pellets_in_first(m_k));
    check("all_eaten", {31'b0, all_eaten}, {31'b0, (m_ready && m_cnt == 0)});
  endtask

  task automatic idle();
    cycle(200, 200, 1'b0, 0, 0);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    eat_req = 1'b0;
    #1;
    check("rst_ready", {31'b0, ready}, 0);
    check("rst_cnt", {22'b0, pellets_left}, 0);
    check("rst_rgb", {17'b0, R, G, B}, 0);
    check("rst_pulse", {30'b0, eat_pellet, eat_power}, 0);
    check("rst_all_eaten", {31'b0, all_eaten}, 0);
    m_ready = 0; m_k = 0; m_cnt = 0;
    @(posedge Clk); #1;
    Reset = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!ready && n < 50) begin
      idle();
      n++;
    end
    check(tag, n, 12);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // T1: reset and init length
    do_reset();
    wait_ready("init_len");
    check("t1_cnt", {22'b0, pellets_left}, 2);
    check("t1_all_eaten", {31'b0, all_eaten}, 0);

    // T2: rendering
    cycle(24, 24, 1'b0, 0, 0); check("t2_pellet", {17'b0, R, G, B}, {17'b0, PEL_RGB});
    cycle(18, 18, 1'b0, 0, 0); check("t2_pel_edge", {17'b0, R, G, B}, 0);
    cycle(36, 20, 1'b0, 0, 0); check("t2_power", {17'b0, R, G, B}, {17'b0, PEL_RGB});
    cycle(5, 5, 1'b0, 0, 0);   check("t2_wall", {17'b0, R, G, B}, {17'b0, WALL_RGB});
    cycle(70, 5, 1'b0, 0, 0);  check("t2_outside", {17'b0, R, G, B}, 0);

    // T3: eats
    cycle(200, 200, 1'b1, 1, 1);
    check("t3_pel_pulse", {31'b0, eat_pellet}, 1);
    check("t3_cnt1", {22'b0, pellets_left}, 1);
    idle(); check("t3_pulse_len", {31'b0, eat_pellet}, 0);
    cycle(200, 200, 1'b1, 1, 1);
    check("t3_repeat", {30'b0, eat_pellet, eat_power}, 0);
    cycle(200, 200, 1'b1, 2, 1);
    check("t3_pow_pulse", {31'b0, eat_power}, 1);
    check("t3_cnt0", {22'b0, pellets_left}, 0);
    check("t3_all_eaten", {31'b0, all_eaten}, 1);
    cycle(36, 20, 1'b0, 0, 0); check("t3_power_gone", {17'b0, R, G, B}, 0);

    // T4: illegal eats (during INIT, wall, out of range)
    do_reset();
    for (int i = 0; i < 12; i++) cycle(200, 200, (i == 3 || i == 10), (i == 3) ? 1 : 2, 1);
    check("t4_ready", {31'b0, ready}, 1);
    check("t4_cnt_init", {22'b0, pellets_left}, 2);
    cycle(200, 200, 1'b1, 0, 0);
    check("t4_wall", {30'b0, eat_pellet, eat_power}, 0);
    cycle(200, 200, 1'b1, 7, 1);
    check("t4_range", {30'b0, eat_pellet, eat_power}, 0);
    check("t4_cnt", {22'b0, pellets_left}, 2);

    // T5: pixel read in the same cycle as the eat sees the old tile
    cycle(24, 24, 1'b1, 1, 1);
    check("t5_old", {17'b0, R, G, B}, {17'b0, PEL_RGB});
    cycle(24, 24, 1'b0, 0, 0);
    check("t5_new", {17'b0, R, G, B}, 0);

    // T6: reset during RUN, then again mid-INIT
    do_reset();
    for (int i = 0; i < 5; i++) idle();
    do_reset();
    wait_ready("t6_init_len");
    check("t6_cnt", {22'b0, pellets_left}, 2);
    cycle(24, 24, 1'b0, 0, 0);
    check("t6_restored", {17'b0, R, G, B}, {17'b0, PEL_RGB});

    // randomized traffic, eats also land during INIT
    for (int r = 0; r < 5; r++) begin
      do_reset();
      for (int i = 0; i < 60; i++) begin
        int dx, dy;
        if ($urandom_range(0, 1) == 1) begin
          dx = TS * int'($urandom_range(0, 3)) + int'($urandom_range(3, 12));
          dy = TS + int'($urandom_range(3, 12));
        end else begin
          dx = int'($urandom_range(0, 79));
          dy = int'($urandom_range(0, 55));
        end
        cycle(dx, dy, ($urandom_range(0, 2) == 0), int'($urandom_range(0, 5)),
              int'($urandom_range(0, 3)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
